// File: rtl/ctrl_pkg.sv
// Shared opcode fields, select codes, state encoding and output bundle for the
// multicycle controller and its instruction decoder.
package ctrl_pkg;

   typedef enum logic [2:0] {
      sIdle,
      sFetch,
      sExec,
      sMem,
      sHalt,
      sFault
   } ctrlState_t;

   typedef enum logic [3:0] {
      clsAluReg,
      clsAluImm,
      clsLoad,
      clsStore,
      clsShift,
      clsBranch,
      clsJump,
      clsCall,
      clsReturn,
      clsHalt,
      clsIllegal
   } instrClass_t;

   // Opcode prefixes, matched against the top bits of instruction[18:13]
   localparam logic [1:0] opAluReg  = 2'b00;
   localparam logic [1:0] opAluImm  = 2'b01;
   localparam logic [2:0] opMem     = 3'b100;
   localparam logic [2:0] opShift   = 3'b110;
   localparam logic [3:0] opBranch  = 4'b1110;
   localparam logic [3:0] opControl = 4'b1111;

   localparam logic [1:0] memLdm  = 2'b00;
   localparam logic [1:0] memStm  = 2'b01;

   localparam logic [1:0] ctlJmp  = 2'b00;
   localparam logic [1:0] ctlJsb  = 2'b01;
   localparam logic [1:0] ctlRet  = 2'b10;
   localparam logic [1:0] ctlHalt = 2'b11;

   localparam logic [1:0] condBz  = 2'b00;
   localparam logic [1:0] condBnz = 2'b01;
   localparam logic [1:0] condBc  = 2'b10;
   localparam logic [1:0] condBnc = 2'b11;

   localparam logic [1:0] wdSelAlu   = 2'b00;
   localparam logic [1:0] wdSelShift = 2'b01;
   localparam logic [1:0] wdSelMem   = 2'b10;

   localparam logic [1:0] pcSelNext   = 2'b00;
   localparam logic [1:0] pcSelBranch = 2'b01;
   localparam logic [1:0] pcSelTarget = 2'b10;

   typedef struct packed {
      logic       pcEn;
      logic       CEn;
      logic       ZEn;
      logic       push;
      logic       pop;
      logic       RET;
      logic       regWrite;
      logic       DMMemWrite;
      logic       DMMemRead;
      logic       regFileReadRegister2Select;
      logic       ALUBInputSelect;
      logic       selectCarry;
      logic [2:0] ALUOperation;
      logic [1:0] SHROOperation;
      logic [1:0] regFileWriteDataSelect;
      logic [1:0] pc3inputMuxSelectAddress;
   } ctrlOut_t;

   function automatic logic branchTaken(input logic [1:0] cond, input logic carry,
                                        input logic zero);
      case (cond)
         condBz:  return zero;
         condBnz: return !zero;
         condBc:  return carry;
         default: return !carry;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction word and flags in, strobes and
// mux selects out. The controller takes the master side.
interface multicycle_controller_if;
   logic [18:0] instruction;
   logic        COutput;
   logic        ZOutput;
   logic        pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemWrite, DMMemRead;
   logic        regFileReadRegister2Select, ALUBInputSelect, selectCarry;
   logic [2:0]  ALUOperation;
   logic [1:0]  SHROOperation, regFileWriteDataSelect, pc3inputMuxSelectAddress;

   modport master (
      input  instruction, COutput, ZOutput,
      output pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemWrite, DMMemRead,
             regFileReadRegister2Select, ALUBInputSelect, selectCarry,
             ALUOperation, SHROOperation, regFileWriteDataSelect, pc3inputMuxSelectAddress
   );

   modport slave (
      output instruction, COutput, ZOutput,
      input  pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemWrite, DMMemRead,
             regFileReadRegister2Select, ALUBInputSelect, selectCarry,
             ALUOperation, SHROOperation, regFileWriteDataSelect, pc3inputMuxSelectAddress
   );
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of the opcode bits instruction[18:13] into an
// instruction class plus the ALU / shift / branch sub-fields.
module instr_decoder
   import ctrl_pkg::*;
(
   input  logic [5:0]  opcode,
   output instrClass_t instrClass,
   output logic [2:0]  aluOp,
   output logic [1:0]  shiftOp,
   output logic [1:0]  branchCond
);

   assign aluOp      = opcode[3:1];
   assign shiftOp    = opcode[2:1];
   assign branchCond = opcode[1:0];

   // Unused encodings (101x, 100 with sub-op 1x) fall through as clsIllegal
   always_comb begin
      instrClass = clsIllegal;
      if (opcode[5:4] == opAluReg) begin
         instrClass = clsAluReg;
      end else if (opcode[5:4] == opAluImm) begin
         instrClass = clsAluImm;
      end else if (opcode[5:3] == opMem) begin
         if (opcode[2:1] == memLdm)      instrClass = clsLoad;
         else if (opcode[2:1] == memStm) instrClass = clsStore;
      end else if (opcode[5:3] == opShift) begin
         instrClass = clsShift;
      end else if (opcode[5:2] == opBranch) begin
         instrClass = clsBranch;
      end else if (opcode[5:2] == opControl) begin
         case (opcode[1:0])
            ctlJmp:  instrClass = clsJump;
            ctlJsb:  instrClass = clsCall;
            ctlRet:  instrClass = clsReturn;
            default: instrClass = clsHalt;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FSM controller (IDLE/FETCH/EXEC/MEM/HALT/FAULT). Define
// CTRL_STACK_CHECK_EN to add return-stack depth tracking with FAULT on overflow/underflow.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int STACK_DEPTH = 8
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   multicycle_controller_if.master        bus,
   output logic                           halted,
   output logic                           fault
);

   ctrlState_t  stateReg, stateNext;
   instrClass_t instrClass;
   logic [2:0]  aluOp;
   logic [1:0]  shiftOp, branchCond;
   logic        stackFault;
   ctrlOut_t    ctrl, ctrlGated;

   instr_decoder decoderInst (
      .opcode     (bus.instruction[18:13]),
      .instrClass (instrClass),
      .aluOp      (aluOp),
      .shiftOp    (shiftOp),
      .branchCond (branchCond)
   );

`ifdef CTRL_STACK_CHECK_EN
   localparam int depthBits = $clog2(STACK_DEPTH + 1);
   logic [depthBits-1:0] depthReg;

   assign stackFault = (instrClass == clsCall   && depthReg == depthBits'(STACK_DEPTH)) ||
                       (instrClass == clsReturn && depthReg == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         depthReg <= '0;
      end else if (stateReg == sExec && !stackFault) begin
         if (instrClass == clsCall)        depthReg <= depthReg + depthBits'(1);
         else if (instrClass == clsReturn) depthReg <= depthReg - depthBits'(1);
      end
   end

   assign fault = (stateReg == sFault);
`else
   assign stackFault = 1'b0;
   assign fault      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) stateReg <= sIdle;
      else      stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      ctrl      = '0;
      case (stateReg)
         sIdle:  if (start) stateNext = sFetch;
         sFetch: stateNext = sExec;
         sExec: begin
            stateNext = sFetch;
            case (instrClass)
               clsAluReg, clsAluImm: begin
                  ctrl.ALUBInputSelect            = (instrClass == clsAluReg);
                  ctrl.regFileReadRegister2Select = 1'b1;
                  ctrl.regWrite                   = 1'b1;
                  ctrl.regFileWriteDataSelect     = wdSelAlu;
                  ctrl.CEn                        = 1'b1;
                  ctrl.ZEn                        = 1'b1;
                  ctrl.ALUOperation               = aluOp;
                  ctrl.pcEn                       = 1'b1;
               end
               clsShift: begin
                  ctrl.SHROOperation          = shiftOp;
                  ctrl.regFileWriteDataSelect = wdSelShift;
                  ctrl.regWrite               = 1'b1;
                  ctrl.CEn                    = 1'b1;
                  ctrl.selectCarry            = 1'b1;
                  ctrl.pcEn                   = 1'b1;
               end
               clsStore: begin
                  ctrl.DMMemWrite = 1'b1;
                  ctrl.pcEn       = 1'b1;
               end
               clsLoad: begin
                  ctrl.DMMemRead = 1'b1;
                  stateNext      = sMem;
               end
               clsBranch: begin
                  ctrl.pcEn = 1'b1;
                  ctrl.pc3inputMuxSelectAddress =
                     branchTaken(branchCond, bus.COutput, bus.ZOutput) ? pcSelBranch : pcSelNext;
               end
               clsJump: begin
                  ctrl.pcEn                     = 1'b1;
                  ctrl.pc3inputMuxSelectAddress = pcSelTarget;
               end
               clsCall: begin
                  if (stackFault) begin
                     stateNext = sFault;
                  end else begin
                     ctrl.push                     = 1'b1;
                     ctrl.pcEn                     = 1'b1;
                     ctrl.pc3inputMuxSelectAddress = pcSelTarget;
                  end
               end
               clsReturn: begin
                  if (stackFault) begin
                     stateNext = sFault;
                  end else begin
                     ctrl.pop  = 1'b1;
                     ctrl.RET  = 1'b1;
                     ctrl.pcEn = 1'b1;
                  end
               end
               clsHalt: stateNext = sHalt;
               // Unassigned encodings behave as a NOP so the program keeps moving
               default: ctrl.pcEn = 1'b1;
            endcase
         end
         sMem: begin
            stateNext                   = sFetch;
            ctrl.DMMemRead              = 1'b1;
            ctrl.regFileWriteDataSelect = wdSelMem;
            ctrl.regWrite               = 1'b1;
            ctrl.pcEn                   = 1'b1;
         end
         default: stateNext = stateReg;
      endcase
   end

   // Strobes are masked while reset is asserted so a reset landing in MEM
   // never commits the load write-back on that edge.
   assign ctrlGated = rst ? ctrl : '0;

   assign bus.pcEn                       = ctrlGated.pcEn;
   assign bus.CEn                        = ctrlGated.CEn;
   assign bus.ZEn                        = ctrlGated.ZEn;
   assign bus.push                       = ctrlGated.push;
   assign bus.pop                        = ctrlGated.pop;
   assign bus.RET                        = ctrlGated.RET;
   assign bus.regWrite                   = ctrlGated.regWrite;
   assign bus.DMMemWrite                 = ctrlGated.DMMemWrite;
   assign bus.DMMemRead                  = ctrlGated.DMMemRead;
   assign bus.regFileReadRegister2Select = ctrlGated.regFileReadRegister2Select;
   assign bus.ALUBInputSelect            = ctrlGated.ALUBInputSelect;
   assign bus.selectCarry                = ctrlGated.selectCarry;
   assign bus.ALUOperation               = ctrlGated.ALUOperation;
   assign bus.SHROOperation              = ctrlGated.SHROOperation;
   assign bus.regFileWriteDataSelect     = ctrlGated.regFileWriteDataSelect;
   assign bus.pc3inputMuxSelectAddress   = ctrlGated.pc3inputMuxSelectAddress;

   assign halted = (stateReg == sHalt);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction stream with
// hand-computed per-cycle output vectors, compared by an independent monitor.
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic halted, fault;

   multicycle_controller_if bus ();

   multicycle_controller #(.STACK_DEPTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus),
      .halted (halted),
      .fault  (fault)
   );

   always #5 clk = ~clk;

   // Vector layout: pcEn CEn ZEn push pop RET regWrite memW memR rr2Sel aluBSel selCarry |
   //                ALUOp[3] SHRO[2] wdSel[2] pcSel[2] | halted fault
   localparam logic [22:0] vIdle    = 23'b0;
   localparam logic [22:0] vAdd     = {12'b111000100110, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [22:0] vAddi    = {12'b111000100100, 3'b101, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [22:0] vShr     = {12'b110000100001, 3'b000, 2'b10, 2'b01, 2'b00, 2'b00};
   localparam logic [22:0] vStm     = {12'b100000010000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [22:0] vLdmExec = {12'b000000001000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [22:0] vLdmMem  = {12'b100000101000, 3'b000, 2'b00, 2'b10, 2'b00, 2'b00};
   localparam logic [22:0] vBrTaken = {12'b100000000000, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00};
   localparam logic [22:0] vBrNot   = {12'b100000000000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [22:0] vJmp     = {12'b100000000000, 3'b000, 2'b00, 2'b00, 2'b10, 2'b00};
   localparam logic [22:0] vJsb     = {12'b100100000000, 3'b000, 2'b00, 2'b00, 2'b10, 2'b00};
   localparam logic [22:0] vRet     = {12'b100011000000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [22:0] vHalted  = {21'b0, 2'b10};
   localparam logic [22:0] vFaulted = {21'b0, 2'b01};

   localparam logic [18:0] insAdd  = {2'b00, 3'b010, 14'h0A5};
   localparam logic [18:0] insAddi = {2'b01, 3'b101, 14'h3F1};
   localparam logic [18:0] insShr  = {3'b110, 2'b10, 14'h012};
   localparam logic [18:0] insStm  = {3'b100, 2'b01, 14'h044};
   localparam logic [18:0] insLdm  = {3'b100, 2'b00, 14'h021};
   localparam logic [18:0] insBz   = {4'b1110, 2'b00, 13'h010};
   localparam logic [18:0] insBnz  = {4'b1110, 2'b01, 13'h020};
   localparam logic [18:0] insBc   = {4'b1110, 2'b10, 13'h030};
   localparam logic [18:0] insBnc  = {4'b1110, 2'b11, 13'h040};
   localparam logic [18:0] insJmp  = {4'b1111, 2'b00, 13'h055};
   localparam logic [18:0] insJsb  = {4'b1111, 2'b01, 13'h066};
   localparam logic [18:0] insRet  = {4'b1111, 2'b10, 13'h000};
   localparam logic [18:0] insHalt = {4'b1111, 2'b11, 13'h000};

   typedef struct {
      logic [22:0] exp;
      string       nm;
   } expItem_t;

   expItem_t sbQ[$];
   int vectors     = 0;
   int miscompares = 0;
   logic [22:0] actual;

   assign actual = {bus.pcEn, bus.CEn, bus.ZEn, bus.push, bus.pop, bus.RET, bus.regWrite,
                    bus.DMMemWrite, bus.DMMemRead, bus.regFileReadRegister2Select,
                    bus.ALUBInputSelect, bus.selectCarry, bus.ALUOperation, bus.SHROOperation,
                    bus.regFileWriteDataSelect, bus.pc3inputMuxSelectAddress, halted, fault};

   // Monitor: every cycle with a pending expectation is compared mid-cycle
   initial begin
      expItem_t it;
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            it = sbQ.pop_front();
            vectors++;
            if (actual !== it.exp) begin
               miscompares++;
               $display("FAIL %s: got %b expected %b", it.nm, actual, it.exp);
            end else begin
               $display("ok   %s: %b", it.nm, actual);
            end
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic [18:0] ins,
                       input logic c, input logic z, input logic [22:0] exp, input string nm);
      expItem_t it;
      @(posedge clk);
      #1;
      rst             = r;
      start           = s;
      bus.instruction = ins;
      bus.COutput     = c;
      bus.ZOutput     = z;
      it.exp          = exp;
      it.nm           = nm;
      sbQ.push_back(it);
   endtask

   // One FETCH cycle followed by the EXEC cycle of the same instruction
   task automatic runInstr(input logic [18:0] ins, input logic c, input logic z,
                           input logic [22:0] exp, input string nm);
      step(1'b1, 1'b0, ins, c, z, vIdle, {nm, "_fetch"});
      step(1'b1, 1'b0, ins, c, z, exp, {nm, "_exec"});
   endtask

   task automatic resetAndStart();
      step(1'b0, 1'b0, insAdd, 1'b0, 1'b0, vIdle, "reset");
      step(1'b1, 1'b0, insAdd, 1'b0, 1'b0, vIdle, "idle");
      step(1'b1, 1'b1, insAdd, 1'b0, 1'b0, vIdle, "idle_start");
   endtask

   initial begin
      rst             = 1'b0;
      start           = 1'b0;
      bus.instruction = '0;
      bus.COutput     = 1'b0;
      bus.ZOutput     = 1'b0;

      resetAndStart();
      runInstr(insAdd,  1'b0, 1'b0, vAdd,  "add_rr");
      runInstr(insAddi, 1'b0, 1'b0, vAddi, "alu_imm");
      runInstr(insShr,  1'b1, 1'b1, vShr,  "shift");
      runInstr(insStm,  1'b0, 1'b0, vStm,  "stm");
      runInstr(insLdm,  1'b0, 1'b0, vLdmExec, "ldm");
      step(1'b1, 1'b0, insLdm, 1'b0, 1'b0, vLdmMem, "ldm_mem");
      runInstr(insBz,   1'b0, 1'b1, vBrTaken, "bz_z1");
      runInstr(insBz,   1'b1, 1'b0, vBrNot,   "bz_z0");
      runInstr(insBnz,  1'b0, 1'b0, vBrTaken, "bnz_z0");
      runInstr(insBc,   1'b1, 1'b0, vBrTaken, "bc_c1");
      runInstr(insBnc,  1'b1, 1'b1, vBrNot,   "bnc_c1");
      runInstr(insJmp,  1'b0, 1'b0, vJmp, "jmp");
      runInstr(insJsb,  1'b0, 1'b0, vJsb, "jsb");
      runInstr(insRet,  1'b0, 1'b0, vRet, "ret");

      // Reset landing in MEM: no write-back strobes, then IDLE
      runInstr(insLdm,  1'b0, 1'b0, vLdmExec, "ldm2");
      step(1'b0, 1'b0, insLdm, 1'b0, 1'b0, vIdle, "ldm_mem_rst");
      step(1'b1, 1'b0, insLdm, 1'b0, 1'b0, vIdle, "after_mem_rst");

      step(1'b1, 1'b1, insHalt, 1'b0, 1'b0, vIdle, "idle_start2");
      runInstr(insHalt, 1'b0, 1'b0, vIdle, "halt");
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'(i % 2), insAdd, 1'b0, 1'b0, vHalted, "halted_hold");
      step(1'b0, 1'b0, insAdd, 1'b0, 1'b0, vHalted, "halted_rst_cycle");
      step(1'b1, 1'b0, insAdd, 1'b0, 1'b0, vIdle, "halt_released");

`ifdef CTRL_STACK_CHECK_EN
      step(1'b1, 1'b1, insRet, 1'b0, 1'b0, vIdle, "idle_start3");
      runInstr(insRet, 1'b0, 1'b0, vIdle, "ret_underflow");
      step(1'b1, 1'b0, insRet, 1'b0, 1'b0, vFaulted, "fault_state");
      step(1'b1, 1'b1, insRet, 1'b0, 1'b0, vFaulted, "fault_ignores_start");
      step(1'b1, 1'b0, insRet, 1'b0, 1'b0, vFaulted, "fault_hold");
      resetAndStart();
      for (int i = 0; i < 8; i++)
         runInstr(insJsb, 1'b0, 1'b0, vJsb, "jsb_fill");
      runInstr(insJsb, 1'b0, 1'b0, vIdle, "jsb_overflow");
      step(1'b1, 1'b0, insJsb, 1'b0, 1'b0, vFaulted, "overflow_fault");
      step(1'b0, 1'b0, insJsb, 1'b0, 1'b0, vFaulted, "fault_rst_cycle");
      step(1'b1, 1'b0, insJsb, 1'b0, 1'b0, vIdle, "fault_released");
`endif

      @(negedge clk);
      @(negedge clk);
      if (sbQ.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
